// File: rtl/stereo_window_gen_pkg.sv
// Shared types and helpers for the stereo 5x5 window generator.
package stereo_window_gen_pkg;

    localparam int WIN = 5;

    // Number of previous rows each stream keeps (window height minus the live row)
    localparam int LB_ROWS = WIN - 1;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [WIN-1:0][WIN-1:0] window_t;

    // Column of one stream entering the window: [0] live pixel, [r] pixel r rows above
    typedef pixel_t [WIN-1:0] column_t;

    // Line buffer entry: [0] row y-1 ... [3] row y-4
    typedef pixel_t [LB_ROWS-1:0] lb_entry_t;

    // Slide the window one column: older columns move to higher c, new column lands at c=0
    function automatic window_t shift_in(input window_t w, input column_t col);
        window_t n;
        for (int r = 0; r < WIN; r++) begin
            n[r][0] = col[r];
            for (int c = 1; c < WIN; c++) begin
                n[r][c] = w[r][c-1];
            end
        end
        return n;
    endfunction

    // Build the incoming column from the live pixel and the four buffered rows
    function automatic column_t make_column(input pixel_t pix, input lb_entry_t rows);
        column_t col;
        col[0] = pix;
        for (int r = 1; r < WIN; r++) begin
            col[r] = rows[r-1];
        end
        return col;
    endfunction

endpackage

// File: rtl/stereo_window_gen_line_buffer_4row.sv
// Four-row line buffer, one entry per column. Each entry holds the pixels of
// the four previous rows at that column. A write pushes the new pixel into the
// youngest slot and ages the others, so the read of the same address in the
// same cycle sees the old contents (read-before-write).
module line_buffer_4row
    import stereo_window_gen_pkg::*;
#(
    parameter int IMG_W = 640
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(IMG_W)-1:0] i_addr,
    input  pixel_t                   i_pixel,
    output lb_entry_t                o_rows
);

    lb_entry_t mem [IMG_W];

    // Asynchronous read of the addressed column, old contents during a write
    always_comb begin
        o_rows = mem[i_addr];
    end

    // Cascade write: row y-1 takes the new pixel, each older row takes its younger neighbour
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= {mem[i_addr][LB_ROWS-2:0], i_pixel};
        end
    end

endmodule

// File: rtl/stereo_window_gen.sv
// Stereo 5x5 window generator. One raster stream per camera; both streams
// share the coordinate counters and the valid. Each accepted pixel shifts a
// new column into that stream's window; the window is flagged valid only once
// it lies fully inside the image (x>=4, y>=4), one cycle after acceptance.
module stereo_window_gen
    import stereo_window_gen_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  pixel_t                   i_pixel_l,
    input  pixel_t                   i_pixel_r,
    output logic                     o_valid,
    output window_t                  o_window_l,
    output window_t                  o_window_r,
    output logic [$clog2(IMG_W)-1:0] o_x,
    output logic [$clog2(IMG_H)-1:0] o_y,
    output logic                     o_frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_FULL = XW'(WIN - 1);
    localparam logic [YW-1:0] Y_FULL = YW'(WIN - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          accept;
    lb_entry_t     rows_l;
    lb_entry_t     rows_r;

    // Coordinates of the pixel presented this cycle; start of frame forces (0,0)
    always_comb begin
        cur_x  = i_sof ? '0 : x;
        cur_y  = i_sof ? '0 : y;
        accept = i_valid & i_rst_n;
    end

    line_buffer_4row #(
        .IMG_W (IMG_W)
    ) u_lb_l (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_addr  (cur_x),
        .i_pixel (i_pixel_l),
        .o_rows  (rows_l)
    );

    line_buffer_4row #(
        .IMG_W (IMG_W)
    ) u_lb_r (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_addr  (cur_x),
        .i_pixel (i_pixel_r),
        .o_rows  (rows_r)
    );

    // Raster counters: advance per accepted pixel, wrap at row and frame end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x <= '0;
            y <= '0;
        end else if (i_valid) begin
            if (cur_x == X_LAST) begin
                x <= '0;
                y <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
            end else begin
                x <= cur_x + XW'(1);
                y <= cur_y;
            end
        end
    end

    // Window shift and registered outputs; stale line-buffer data only reaches
    // windows with y<4, which are never flagged valid
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_window_l   <= '0;
            o_window_r   <= '0;
            o_x          <= '0;
            o_y          <= '0;
        end else begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_valid) begin
                o_window_l   <= shift_in(o_window_l, make_column(i_pixel_l, rows_l));
                o_window_r   <= shift_in(o_window_r, make_column(i_pixel_r, rows_r));
                o_x          <= cur_x;
                o_y          <= cur_y;
                o_valid      <= (cur_x >= X_FULL) && (cur_y >= Y_FULL);
                o_frame_done <= (cur_x == X_LAST) && (cur_y == Y_LAST);
            end
        end
    end

endmodule

// File: tb/tb_stereo_window_gen.sv
// Directed bench for stereo_window_gen on an 8x6 ramp image (pixel = 16*y+x,
// right stream = 255 - left).
module tb_stereo_window_gen;
    import stereo_window_gen_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 200;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          i_sof;
    pixel_t        i_pixel_l;
    pixel_t        i_pixel_r;
    logic          o_valid;
    window_t       o_window_l;
    window_t       o_window_r;
    logic [2:0]    o_x;
    logic [2:0]    o_y;
    logic          o_frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;

    stereo_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .i_pixel_l    (i_pixel_l),
        .i_pixel_r    (i_pixel_r),
        .o_valid      (o_valid),
        .o_window_l   (o_window_l),
        .o_window_r   (o_window_r),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_done (o_frame_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic pixel_t ramp(input int x, input int y);
        return 8'(16 * y + x);
    endfunction

    // Expected window straight from the indexing rule: [r][c] = pixel(x-c, y-r)
    function automatic window_t exp_win(input int x, input int y, input bit right);
        window_t w;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                w[r][c] = right ? 8'(255 - (16 * (y - r) + (x - c))) : ramp(x - c, y - r);
            end
        end
        return w;
    endfunction

    // Present one cycle (pixel or bubble) and check the outputs #1 after the edge
    task automatic send_pix(input bit v, input bit sof, input int ex, input int ey);
        bit exp_v;
        i_valid   = v;
        i_sof     = sof;
        i_pixel_l = ramp(ex, ey);
        i_pixel_r = 8'(255 - (16 * ey + ex));
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        if (o_valid) n_valid++;
        if (v) begin
            exp_v = (ex >= 4) && (ey >= 4);
            check("valid", CW'(o_valid), CW'(exp_v));
            check("frame_done", CW'(o_frame_done), CW'((ex == W - 1) && (ey == H - 1)));
            if (exp_v) begin
                check("o_x", CW'(o_x), CW'(ex));
                check("o_y", CW'(o_y), CW'(ey));
                check("win_l", CW'(o_window_l), CW'(exp_win(ex, ey, 1'b0)));
                check("win_r", CW'(o_window_r), CW'(exp_win(ex, ey, 1'b1)));
                if (ex == 4 && ey == 4) begin
                    check("first_00", CW'(o_window_l[0][0]), CW'(8'h44));
                    check("first_10", CW'(o_window_l[1][0]), CW'(8'h34));
                    check("first_01", CW'(o_window_l[0][1]), CW'(8'h43));
                    check("first_44", CW'(o_window_l[4][4]), CW'(8'h00));
                end
                if (ex == W - 1 && ey == H - 1) begin
                    check("last_00", CW'(o_window_l[0][0]), CW'(8'h57));
                    check("last_r00", CW'(o_window_r[0][0]), CW'(8'hA8));
                end
            end
        end else begin
            check("bubble_valid", CW'(o_valid), CW'(0));
            check("bubble_fdone", CW'(o_frame_done), CW'(0));
        end
    endtask

    task automatic send_frame(input bit sof_first, input bit bubbles);
        n_valid = 0;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                send_pix(1'b1, sof_first && xx == 0 && yy == 0, xx, yy);
                if (bubbles) send_pix(1'b0, 1'b0, 0, 0);
            end
        end
        check("valid_count", CW'(n_valid), CW'(8));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, CW'(o_valid), CW'(0));
        check({tag, "_fdone"}, CW'(o_frame_done), CW'(0));
        check({tag, "_win_l"}, CW'(o_window_l), CW'(0));
        check({tag, "_win_r"}, CW'(o_window_r), CW'(0));
        check({tag, "_x"}, CW'(o_x), CW'(0));
        check({tag, "_y"}, CW'(o_y), CW'(0));
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_sof     = 1'b0;
        i_pixel_l = '0;
        i_pixel_r = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_cleared("reset");
        i_rst_n = 1'b1;

        // Idle: nothing advances without i_valid
        for (int i = 0; i < 20; i++) send_pix(1'b0, 1'b1, 0, 0);
        check_cleared("idle");

        // Continuous ramp frame
        send_frame(1'b1, 1'b0);

        // Same frame with a bubble after every pixel
        send_frame(1'b1, 1'b1);

        // Partial frame up to (2,2), then start of frame arrives where (3,2) would be
        for (int i = 0; i < 2 * W + 3; i++) send_pix(1'b1, i == 0, i % W, i / W);
        send_frame(1'b1, 1'b0);

        // Partial frame into row 4, then a one-cycle reset
        for (int i = 0; i < 4 * W + 6; i++) send_pix(1'b1, i == 0, i % W, i / W);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        check_cleared("mid_reset");
        i_rst_n = 1'b1;
        send_frame(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stereo_window_gen.md
Name: stereo_window_gen

Overview:
- Upstream neighbour of the edge-distance and matching-cost stages.
- Accepts one synchronised raster pixel stream per camera (left, right) and produces a 5x5 neighbourhood window per stream for every pixel with a full window.
- Four per-stream line buffers hold the previous rows; a 5x5 register array slides horizontally.
- Emits windows plus pixel coordinates with a single valid, 1-cycle latency.

Parameters:
- IMG_W, 640, active pixels per row (>= 8)
- IMG_H, 480, active rows per frame (>= 5)
- WIN, 5, window size; fixed, not overridable in this revision

Ports:
- i_clk  in  1  clock; only clock in the block
- i_rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  i_pixel_l/i_pixel_r carry a pixel this cycle
- i_sof  in  1  start of frame; qualifies the pixel accepted in the same cycle
- i_pixel_l  in  8  left pixel
- i_pixel_r  in  8  right pixel
- o_valid  out  1  window outputs valid
- o_window_l  out  8 x [4:0][4:0]  left window
- o_window_r  out  8 x [4:0][4:0]  right window
- o_x  out  $clog2(IMG_W)  column of window[0][0]
- o_y  out  $clog2(IMG_H)  row of window[0][0]
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (i_rst_n low at a posedge): synchronous only.
  - Clears o_valid, o_frame_done, both windows (all 0), o_x, o_y, and the internal counters x and y.
  - Line-buffer contents are not reset. The y>=4 masking guarantees they are never exposed.
  - A reset mid-frame forces the next accepted pixel to be treated as (0,0).
- Accept: a pixel is accepted on any posedge with i_valid=1. With i_valid=0 nothing advances: counters, windows and line buffers hold, and o_valid=0 next cycle.
- Coordinates:
  - If i_sof=1 with i_valid=1, the pixel is (0,0). Otherwise it is (x,y).
  - After acceptance, x increments. At IMG_W-1, x wraps to 0 and y increments. At (IMG_W-1, IMG_H-1), both wrap to 0.
  - i_sof with i_valid=0 is ignored.
- Window indexing: window[r][c] is the pixel at row y-r, column x-c. [0][0] is the newest pixel and [1][0] is the pixel directly above it.
- Per accepted pixel, per stream:
  - Read column x of the line buffers: lb0 holds row y-1 … lb3 holds row y-4.
  - Write the cascade lb0[x]<=pix, lb1[x]<=old lb0[x], lb2[x]<=old lb1[x], lb3[x]<=old lb2[x]. This is read-before-write in the same cycle.
  - Shift window columns: window[r][c]<=window[r][c-1] for c=1..4; window[*][0]<={pix, lb0[x], lb1[x], lb2[x], lb3[x]}.
- Output timing:
  - o_valid=1 on the cycle after acceptance iff accepted x>=4 and y>=4. o_x/o_y register the accepted coordinates. Latency is exactly 1 cycle.
  - Windows that straddle a row boundary (x<4) are never flagged valid.
- o_frame_done: 1-cycle pulse on the cycle after acceptance of (IMG_W-1, IMG_H-1), coincident with that pixel's o_valid.
- Streams: left and right share counters and valid and are processed identically and independently. No cross-stream arithmetic.
- No backpressure: the downstream stage must accept every o_valid cycle.

Decomposition:
- Shared package holds:
  - typedef pixel_t (logic [7:0])
  - typedef window_t (pixel_t [4:0][4:0])
  - localparam WIN=5
- Sub-module line_buffer_4row (IMG_W deep, 4x8-bit wide, cascade read-before-write):
  - one instance per stream
  - inferred as block RAM or shift registers per target

Test Plan:
- Reset, idle: reset for 3 cycles, i_valid=0 for 20 cycles -> o_valid=0, windows all 0, o_x=o_y=0, o_frame_done=0.
- Ramp image: IMG_W=8, IMG_H=6, pixel=16*y+x, i_sof on the first pixel, continuous valid.
  - First o_valid one cycle after pixel (4,4), with [0][0]=0x44, [1][0]=0x34, [0][1]=0x43, [4][4]=0x00.
  - Exactly 8 valid outputs.
  - o_frame_done together with (7,5), [0][0]=0x57.
- Bubbles: same image with i_valid toggling 1/0 -> identical sequence of valid windows and coordinates, each 1 cycle after its accepting edge.
- i_sof mid-frame: assert on pixel (3,2) -> that pixel becomes (0,0); no o_valid until new (4,4); windows thereafter match a fresh ramp.
- Reset mid-frame: i_rst_n low for 1 cycle during row 4 -> outputs 0 on the next cycle; subsequent pixels restart at (0,0); no o_valid for 4 rows.
- Stream independence: right = 255 - left ramp -> every valid o_window_r element equals 255 minus the matching o_window_l element.
